// File: rtl/input_port_requester.sv
// Ingress requester for one switch input port: buffers framed flits, presents the
// header destination mask to the arbiter and streams the packet on granted cycles.
module input_port_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int DST_WIDTH  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_sop,
  input  logic                          in_eop,
  output logic                          port_req,
  output logic [DST_WIDTH-1:0]          port_dst,
  input  logic                          grant,
  output logic                          port_lock,
  output logic                          xbar_valid,
  output logic [DATA_WIDTH-1:0]         xbar_data,
  output logic                          xbar_sop,
  output logic                          xbar_eop,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          count_q, count_d;
  logic [DST_WIDTH-1:0]   dst_q, dst_d;
  logic                   lock_q, lock_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;

  logic                   empty, full, push, pop, drop_inc;
  logic [EW-1:0]          head;
  logic                   head_sop, head_eop;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [DST_WIDTH-1:0]   head_mask;

  // Handshakes: an ingress flit transfers on a cycle with in_valid & in_ready;
  // a flit transfers to the crossbar on a cycle with port_req & grant, which is
  // exactly when xbar_valid is high. Full uses the registered count only.
  assign empty     = (count_q == '0);
  assign full      = (count_q == LW'(FIFO_DEPTH));
  assign in_ready  = rst_n & ~full;
  assign push      = in_valid & in_ready;

  assign head      = mem_q[rd_ptr_q];
  assign head_sop  = head[EW-1];
  assign head_eop  = head[EW-2];
  assign head_data = head[DATA_WIDTH-1:0];
  assign head_mask = head_data[DST_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    dst_d      = dst_q;
    lock_d     = lock_q;
    pop        = 1'b0;
    drop_inc   = 1'b0;
    port_req   = 1'b0;
    port_dst   = '0;
    xbar_valid = 1'b0;
    xbar_data  = '0;
    xbar_sop   = 1'b0;
    xbar_eop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (!head_sop) begin
            pop      = 1'b1;
            drop_inc = 1'b1;
          end else if (head_mask == '0) begin
            // An empty mask is never granted, so the packet is discarded instead.
            drop_inc = 1'b1;
            state_d  = DROP;
          end else begin
            dst_d   = head_mask;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (rst_n) begin
          port_dst = dst_q;
          port_req = ~empty;
        end
        if (port_req && grant) begin
          pop        = 1'b1;
          xbar_valid = 1'b1;
          xbar_data  = head_data;
          xbar_sop   = head_sop;
          xbar_eop   = head_eop;
          lock_d     = ~head_eop;
          if (head_eop) state_d = IDLE;
        end
      end
      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_eop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    drop_d = (drop_inc && (drop_q != '1)) ? drop_q + CNT_WIDTH'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dst_q    <= '0;
      lock_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dst_q    <= dst_d;
      lock_q   <= lock_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_sop, in_eop, in_data};
  end

  assign port_lock  = lock_q;
  assign drop_cnt   = drop_q;
  assign fifo_level = count_q;

endmodule

// File: doc/input_port_requester.md
Name: input_port_requester

Overview:
- Ingress-side initiator for the 4-port switch arbitration handshake.
- Buffers framed packets from one ingress link in a local FIFO and extracts the destination mask from the header flit.
- Drives the per-port request and destination-mask inputs of the switch arbiter, holding them steady until granted.
- Streams flits toward the crossbar only on granted cycles. One instance per input port.

Parameters:
- DATA_WIDTH, 32, flit payload width; header flit carries the destination mask in bits [DST_WIDTH-1:0].
- DST_WIDTH, 4, destination mask width; one bit per output port, multicast allowed.
- FIFO_DEPTH, 16, flit entries; must be a power of 2, at least 2.
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  ingress flit valid
- in_ready  out  1  ingress flit accepted when in_valid&in_ready
- in_data  in  DATA_WIDTH  ingress flit payload
- in_sop  in  1  first flit of packet
- in_eop  in  1  last flit of packet
- port_req  out  1  request to arbiter
- port_dst  out  DST_WIDTH  destination mask presented to arbiter
- grant  in  1  arbiter grant for this port; combinational, same cycle as request
- port_lock  out  1  packet in flight; stays high after the first granted flit until the EOP flit is granted
- xbar_valid  out  1  flit driven to crossbar this cycle
- xbar_data  out  DATA_WIDTH  flit payload to crossbar
- xbar_sop  out  1  flit is SOP
- xbar_eop  out  1  flit is EOP
- drop_cnt  out  CNT_WIDTH  saturating count of discarded packets and orphan flits
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: synchronous, active-low, takes effect on the clk edge.
  - FIFO flushed; fifo_level=0; drop_cnt=0; FSM to IDLE; latched destination mask=0.
  - in_ready=0 while rst_n=0.
  - port_req, port_dst, port_lock, xbar_valid, xbar_sop and xbar_eop all 0.
- FIFO:
  - Each entry stores {sop, eop, data}.
  - in_ready = rst_n & !full. Full is based on the registered count only; a same-cycle pop does not free space for a push.
  - Push and pop in the same cycle leave the level unchanged.
  - A pushed flit is visible at the head on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SEND, DROP.
- IDLE (port_req=0, port_lock=0):
  - FIFO empty: stay in IDLE.
  - Head sop=0 (orphan flit): pop it, drop_cnt+1, stay in IDLE.
  - Head sop=1 and head data[DST_WIDTH-1:0]==0: do not pop; drop_cnt+1; go to DROP. This case would otherwise deadlock, because the arbiter never grants an empty mask.
  - Head sop=1 and mask!=0: latch the mask into dst_q; go to SEND. No pop.
- SEND:
  - port_dst=dst_q, held constant for the whole packet.
  - port_req = !empty.
  - port_req & grant: pop the head flit; xbar_valid=1 with xbar_data/sop/eop driven combinationally from the head entry. This cycle is the handshake.
  - grant while port_req=0: ignored.
  - Granted flit with eop=1: go to IDLE next cycle and clear port_lock. A single-flit packet (sop&eop) completes in one grant.
  - No grant: hold all outputs; no pop.
- DROP: pop one flit per cycle while the FIFO is non-empty, with xbar_valid=0. Return to IDLE after the popped flit has eop=1.
- port_lock: set on the cycle after the first granted flit of the packet (registered); cleared on the cycle after the EOP is granted.
- port_dst=0 whenever the FSM is not in SEND.
- drop_cnt saturates at 2^CNT_WIDTH-1.
- Latency: push at cycle N → FSM enters SEND at N+2 → port_req earliest at N+2, and that cycle is the first flit transfer if grant=1.
- Framing inside a packet (a SOP appearing before EOP) is not checked; upstream guarantees it.
- Reset mid-packet: the packet is lost; no partial flush toward the crossbar.

Test Plan:
- Single-flit unicast: push sop=eop=1, data=0x0000_0002 at cycle 0, grant tied high.
  - Required: port_req=1 and port_dst=4'b0010 at cycle 2; xbar_valid=1 with sop=eop=1 at cycle 2; port_req=0 at cycle 3.
- 4-flit multicast, mask 4'b1010, grant=0 for 5 cycles, then alternating 1/0.
  - Required: port_req and port_dst held steady while waiting, no pops.
  - Flits then emerge only on grant=1 cycles, in order, sop on the first and eop on the 4th.
  - port_lock high from after the first grant until the cycle after EOP.
- Zero-mask packet of 3 flits followed by a valid 2-flit packet with mask 4'b0001.
  - Required: no port_req for the first packet; drop_cnt=1; second packet forwarded normally.
- Orphan flit with sop=0 arriving in IDLE.
  - Required: discarded within 1 cycle of reaching the head; drop_cnt increments; no port_req.
- Backpressure: 16 flits pushed with grant=0.
  - Required: fifo_level=16, in_ready=0. One granted cycle → fifo_level=15 and in_ready=1 on the next cycle.
- Reset mid-packet: assert rst_n=0 for 1 cycle after 2 of 4 flits have been granted.
  - Required: every output 0 at the next edge and fifo_level=0; the next packet is processed from IDLE normally.
